// File: rtl/game_pkg.sv
// game_pkg: shared widths, hit entry record and frame FSM state encoding
// for the sprite hit detection slice.
//   COL_W / ROW_W   pixel column / row widths
//   COLOR_W         layer pixel width: [24:1] RGB, [VISIBLE_BIT] visible flag
//   hit_t           FIFO entry {row, col}
//   state_t         frame FSM states
package game_pkg;

  localparam int COL_W       = 12;
  localparam int ROW_W       = 11;
  localparam int COLOR_W     = 25;
  localparam int VISIBLE_BIT = 0;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } hit_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    SCAN       = 2'd1,
    END_FRAME  = 2'd2
  } state_t;

endpackage

// File: rtl/hit_fifo.sv
// hit_fifo: synchronous FIFO of hit entries, DEPTH entries (power of two).
//   clock  rising-edge clock
//   reset  asynchronous active-low clear (pointers and storage)
//   push   write din when not full (or when a pop happens in the same cycle)
//   pop    advance head when not empty
//   din    entry to store
//   dout   current head entry (combinational read)
//   full   DEPTH entries held
//   empty  no entries held
module hit_fifo
  import game_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  hit_t din,
  output hit_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra bit so full and empty can be told apart.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  hit_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    do_push = push & (~full | do_pop);
    dout    = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < 32'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hit_detector.sv
// hit_detector: finds bullet/enemy overlap run starts during active scan,
// queues their {row,col} in a FIFO and reports per-frame hit statistics.
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   calc          1 = blanking/compute window, 0 = active scan
//   display_col   current pixel column
//   display_row   current pixel row
//   bullet_color  bullet layer pixel, [0] visible
//   enemy_color   enemy layer pixel, [0] visible
//   hit_ready     consumer accepts head entry
//   hit_valid     FIFO non-empty
//   hit_x/hit_y   column/row of head entry
//   hit_count     accepted hits of the previous frame (saturating at 255)
//   overflow      sticky within a frame: a hit was dropped on a full FIFO
// Build option: define HIT_DEDUP_EN to suppress run starts that continue a
// sprite from the previous row (row = last_row+1, |col-last_col| < SIZE).
module hit_detector
  import game_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SIZE  = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               calc,
  input  logic [COL_W-1:0]   display_col,
  input  logic [ROW_W-1:0]   display_row,
  input  logic [COLOR_W-1:0] bullet_color,
  input  logic [COLOR_W-1:0] enemy_color,
  input  logic               hit_ready,
  output logic               hit_valid,
  output logic [COL_W-1:0]   hit_x,
  output logic [ROW_W-1:0]   hit_y,
  output logic [7:0]         hit_count,
  output logic               overflow
);

  logic             calc_q;
  logic             ovl_q;
  logic             ovl_prev;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  state_t           state;
  logic             armed;
  logic [7:0]       frame_cnt;
  logic             active;
  logic             cand;
  logic             suppress;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             accept;
  logic             drop;
  hit_t             entry;
  hit_t             head;
  logic             unused_color;

  // Only the visible flags matter here; the RGB fields are ignored.
  assign unused_color = ^{bullet_color, enemy_color};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      calc_q   <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      ovl_q    <= 1'b0;
      ovl_prev <= 1'b0;
    end else begin
      calc_q   <= calc;
      col_q    <= display_col;
      row_q    <= display_row;
      ovl_q    <= bullet_color[VISIBLE_BIT] & enemy_color[VISIBLE_BIT];
      ovl_prev <= ovl_q;
    end
  end

  // armed records that a blanking window has been seen, so that after reset
  // the FSM waits for a complete active period instead of joining mid-frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= WAIT_FRAME;
      armed <= 1'b0;
    end else begin
      if (calc_q) begin
        armed <= 1'b1;
      end else if (state == WAIT_FRAME) begin
        armed <= 1'b0;
      end
      case (state)
        WAIT_FRAME: if (armed && !calc_q) state <= SCAN;
        SCAN:       if (calc_q) state <= END_FRAME;
        END_FRAME:  state <= WAIT_FRAME;
        default:    state <= WAIT_FRAME;
      endcase
    end
  end

  // The first active pixel arrives while the FSM is still leaving WAIT_FRAME;
  // counting that cycle as scanning keeps pixel (row,0) of the frame.
  always_comb begin
    active = ~calc_q & ((state == SCAN) | ((state == WAIT_FRAME) & armed));
    cand   = active & ovl_q & (~ovl_prev | (col_q == '0));
  end

`ifdef HIT_DEDUP_EN
  localparam logic [COL_W:0] SIZE_W = (COL_W+1)'(SIZE);

  logic [ROW_W-1:0] last_row;
  logic [COL_W-1:0] last_col;
  logic [COL_W:0]   col_diff;
  logic [COL_W:0]   col_dist;

  always_comb begin
    col_diff = {1'b0, col_q} - {1'b0, last_col};
    col_dist = col_diff[COL_W] ? (~col_diff + 1'b1) : col_diff;
    suppress = (row_q == (last_row + ROW_W'(1))) && (col_dist < SIZE_W);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_row <= '0;
      last_col <= '0;
    end else if (state == END_FRAME) begin
      last_row <= '0;
      last_col <= '0;
    end else if (cand) begin
      last_row <= row_q;
      last_col <= col_q;
    end
  end
`else
  logic unused_size;
  assign unused_size = (SIZE != 0);

  always_comb begin
    suppress = 1'b0;
  end
`endif

  always_comb begin
    push      = cand & ~suppress;
    hit_valid = ~empty;
    pop       = hit_valid & hit_ready;
    accept    = push & (~full | pop);
    drop      = push & full & ~pop;
    entry.row = row_q;
    entry.col = col_q;
    hit_x     = head.col;
    hit_y     = head.row;
  end

  hit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
    end else if (state == END_FRAME) begin
      hit_count <= frame_cnt;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (accept && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
// tb_hit_detector: directed frame scenarios for hit_detector. Each scenario
// lists overlap rectangles and the hand-computed FIFO contents, hit_count and
// overflow; expectations differ only where HIT_DEDUP_EN changes behaviour.
module tb_hit_detector;

  localparam int DEPTH = 4;
  localparam int SIZE  = 32;
  localparam int ROW_LO = 48;
  localparam int ROW_HI = 57;
  localparam int NCOL   = 128;

`ifdef HIT_DEDUP_EN
  localparam int DEDUP = 1;
`else
  localparam int DEDUP = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        calc;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic [24:0] bullet_color;
  logic [24:0] enemy_color;
  logic        hit_ready;
  logic        hit_valid;
  logic [11:0] hit_x;
  logic [10:0] hit_y;
  logic [7:0]  hit_count;
  logic        overflow;

  always #5 clock = ~clock;

  hit_detector #(
    .DEPTH (DEPTH),
    .SIZE  (SIZE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .calc         (calc),
    .display_col  (display_col),
    .display_row  (display_row),
    .bullet_color (bullet_color),
    .enemy_color  (enemy_color),
    .hit_ready    (hit_ready),
    .hit_valid    (hit_valid),
    .hit_x        (hit_x),
    .hit_y        (hit_y),
    .hit_count    (hit_count),
    .overflow     (overflow)
  );

  // kind: 0 both layers visible, 1 bullet only, 2 enemy only
  typedef struct packed { int sc; int r0; int c0; int h; int w; int kind; } rect_t;
  // mode: 0 always expected, 1 only with dedup, 2 only without dedup
  typedef struct packed { int sc; int mode; int x; int y; } ent_t;
  typedef struct packed { int cnt_dd; int cnt_nd; int ovf; int pop_r; int pop_c; } scen_t;

  rect_t rects[$];
  ent_t  ents[$];
  scen_t scens[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void vis(input int sc, input int r, input int c,
                              output bit b, output bit e);
    b = 1'b0;
    e = 1'b0;
    foreach (rects[i]) begin
      if (rects[i].sc == sc && r >= rects[i].r0 && r < rects[i].r0 + rects[i].h &&
          c >= rects[i].c0 && c < rects[i].c0 + rects[i].w) begin
        if (rects[i].kind != 2) b = 1'b1;
        if (rects[i].kind != 1) e = 1'b1;
      end
    end
  endfunction

  // Drive one pixel (inputs change 1 time unit after the rising edge) and
  // advance to just after the next rising edge.
  task automatic drive_px(input bit cl, input int r, input int c, input bit b, input bit e);
    calc         = cl;
    display_row  = 11'(r);
    display_col  = 12'(c);
    bullet_color = {24'($urandom), b};
    enemy_color  = {24'($urandom), e};
    @(posedge clock);
    #1;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive_px(1'b1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic run_scen(input int sc);
    bit b, e;
    int pr, pc, exp_cnt, nexp;
    pr = -1;
    pc = -1;
    blank(4);
    for (int r = ROW_LO; r <= ROW_HI; r++) begin
      for (int c = 0; c < NCOL; c++) begin
        vis(sc, r, c, b, e);
        hit_ready = (pr == scens[sc].pop_r) && (pc == scens[sc].pop_c);
        drive_px(1'b0, r, c, b, e);
        pr = r;
        pc = c;
      end
    end
    hit_ready = 1'b0;
    drive_px(1'b0, ROW_HI, 0, 1'b0, 1'b0);
    drive_px(1'b0, ROW_HI, 1, 1'b0, 1'b0);
    chk($sformatf("s%0d_overflow_scan", sc), int'(overflow), scens[sc].ovf);
    blank(6);
    exp_cnt = DEDUP ? scens[sc].cnt_dd : scens[sc].cnt_nd;
    chk($sformatf("s%0d_hit_count", sc), int'(hit_count), exp_cnt);
    chk($sformatf("s%0d_overflow_cleared", sc), int'(overflow), 0);
    nexp = 0;
    foreach (ents[i]) begin
      if (ents[i].sc == sc && (ents[i].mode == 0 ||
          (ents[i].mode == 1 && DEDUP == 1) || (ents[i].mode == 2 && DEDUP == 0))) begin
        chk($sformatf("s%0d_e%0d_valid", sc, nexp), int'(hit_valid), 1);
        chk($sformatf("s%0d_e%0d_x", sc, nexp), int'(hit_x), ents[i].x);
        chk($sformatf("s%0d_e%0d_y", sc, nexp), int'(hit_y), ents[i].y);
        hit_ready = 1'b1;
        @(posedge clock);
        #1;
        hit_ready = 1'b0;
        nexp++;
      end
    end
    chk($sformatf("s%0d_drained", sc), int'(hit_valid), 0);
  endtask

  initial begin
    // S0: 4x4 sprite overlap at col 100, rows 50-53
    rects.push_back('{0, 50, 100, 4, 4, 0});
    ents.push_back('{0, 1, 100, 50});
    ents.push_back('{0, 2, 100, 50});
    ents.push_back('{0, 2, 100, 51});
    ents.push_back('{0, 2, 100, 52});
    ents.push_back('{0, 2, 100, 53});
    scens.push_back('{1, 4, 0, -1, -1});
    // S1: row right below the previous frame's last hit; dedup record must be clear
    rects.push_back('{1, 54, 100, 1, 1, 0});
    ents.push_back('{1, 0, 100, 54});
    scens.push_back('{1, 1, 0, -1, -1});
    // S2: six separated overlaps, FIFO keeps the first four
    rects.push_back('{2, 49, 10, 1, 3, 0});
    rects.push_back('{2, 49, 80, 1, 3, 0});
    rects.push_back('{2, 51, 10, 1, 3, 0});
    rects.push_back('{2, 51, 80, 1, 3, 0});
    rects.push_back('{2, 53, 10, 1, 3, 0});
    rects.push_back('{2, 53, 80, 1, 3, 0});
    ents.push_back('{2, 0, 10, 49});
    ents.push_back('{2, 0, 80, 49});
    ents.push_back('{2, 0, 10, 51});
    ents.push_back('{2, 0, 80, 51});
    scens.push_back('{4, 4, 1, -1, -1});
    // S3: two-row sprite plus a distant hit on the following row
    rects.push_back('{3, 50, 20, 2, 3, 0});
    rects.push_back('{3, 52, 90, 1, 2, 0});
    ents.push_back('{3, 0, 20, 50});
    ents.push_back('{3, 2, 20, 51});
    ents.push_back('{3, 0, 90, 52});
    scens.push_back('{2, 3, 0, -1, -1});
    // S4: column distance 31 (suppressed) vs 32 (kept); single-layer runs never hit
    rects.push_back('{4, 50, 40, 1, 1, 0});
    rects.push_back('{4, 51, 71, 1, 1, 0});
    rects.push_back('{4, 52, 103, 1, 1, 0});
    rects.push_back('{4, 55, 10, 1, 11, 1});
    rects.push_back('{4, 56, 30, 1, 11, 2});
    ents.push_back('{4, 0, 40, 50});
    ents.push_back('{4, 2, 71, 51});
    ents.push_back('{4, 0, 103, 52});
    scens.push_back('{2, 3, 0, -1, -1});
    // S5: overlap runs off the end of row 53 and continues at col 0 of row 54
    rects.push_back('{5, 53, 124, 1, 4, 0});
    rects.push_back('{5, 54, 0, 1, 4, 0});
    ents.push_back('{5, 0, 124, 53});
    ents.push_back('{5, 0, 0, 54});
    scens.push_back('{2, 2, 0, -1, -1});
    // S6: fifth push meets a pop on a full FIFO; nothing is dropped
    rects.push_back('{6, 49, 10, 1, 1, 0});
    rects.push_back('{6, 49, 30, 1, 1, 0});
    rects.push_back('{6, 49, 50, 1, 1, 0});
    rects.push_back('{6, 49, 70, 1, 1, 0});
    rects.push_back('{6, 49, 90, 1, 1, 0});
    ents.push_back('{6, 0, 30, 49});
    ents.push_back('{6, 0, 50, 49});
    ents.push_back('{6, 0, 70, 49});
    ents.push_back('{6, 0, 90, 49});
    scens.push_back('{5, 5, 0, 49, 90});

    reset        = 1'b0;
    hit_ready    = 1'b0;
    calc         = 1'b1;
    display_col  = '0;
    display_row  = '0;
    bullet_color = '0;
    enemy_color  = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_hit_valid", int'(hit_valid), 0);
    chk("reset_hit_x", int'(hit_x), 0);
    chk("reset_hit_y", int'(hit_y), 0);
    chk("reset_hit_count", int'(hit_count), 0);
    chk("reset_overflow", int'(overflow), 0);
    reset = 1'b1;

    for (int s = 0; s < scens.size(); s++) begin
      run_scen(s);
    end

    // Popping an empty FIFO must leave it empty.
    hit_ready = 1'b1;
    blank(2);
    hit_ready = 1'b0;
    chk("pop_empty_valid", int'(hit_valid), 0);

    // Reset mid-scan with two entries queued, then a full new frame.
    blank(4);
    for (int c = 0; c < 64; c++) begin
      drive_px(1'b0, 49, c, (c == 10 || c == 40), (c == 10 || c == 40));
    end
    chk("rst_pre_valid", int'(hit_valid), 1);
    reset = 1'b0;
    #1;
    chk("rst_valid_async", int'(hit_valid), 0);
    chk("rst_hit_x_async", int'(hit_x), 0);
    #1;
    drive_px(1'b0, 49, 64, 1'b0, 1'b0);
    drive_px(1'b0, 49, 65, 1'b0, 1'b0);
    reset = 1'b1;
    for (int c = 66; c < NCOL; c++) begin
      drive_px(1'b0, 49, c, (c == 80 || c == 100), (c == 80 || c == 100));
    end
    drive_px(1'b0, 50, 0, 1'b1, 1'b1);
    drive_px(1'b0, 50, 1, 1'b0, 1'b0);
    drive_px(1'b0, 50, 2, 1'b0, 1'b0);
    chk("rst_no_push_partial_frame", int'(hit_valid), 0);
    blank(4);
    for (int c = 0; c < 40; c++) begin
      drive_px(1'b0, 49, c, (c == 20), (c == 20));
    end
    chk("rst_next_frame_valid", int'(hit_valid), 1);
    chk("rst_next_frame_x", int'(hit_x), 20);
    chk("rst_next_frame_y", int'(hit_y), 49);
    blank(6);
    chk("rst_next_frame_count", int'(hit_count), 1);
    hit_ready = 1'b1;
    @(posedge clock);
    #1;
    hit_ready = 1'b0;
    chk("rst_next_frame_drained", int'(hit_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
